// File: rtl/pkt_bram_reader.sv
// Packet read engine: walks BRAM from cmd_addr for cmd_len words into a valid/ready stream.
// Optional packet/word counters under PKT_BRAM_READER_STATS_EN.
module pkt_bram_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
`ifdef PKT_BRAM_READER_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [31:0]           word_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] raddr;
  logic [LEN_WIDTH-1:0]  rem;
  logic                  infl;
  logic                  infl_last;
  logic [DATA_WIDTH-1:0] bdata [2];
  logic                  blast [2];
  logic                  wptr;
  logic                  rptr;
  logic [1:0]            occ;
  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic                  push;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign m_valid    = (occ != 2'd0);
  assign pop        = m_valid && m_ready;
  assign push       = infl;
  assign m_data     = bdata[rptr];
  assign m_last     = m_valid && blast[rptr];
  assign bram_raddr = raddr;
  assign bram_re    = issue;

  // A pop frees a slot this cycle, so a read may be issued against it
  always_comb begin
    issue    = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (cmd_len == '0) ? DONE : READ;
      end
      READ: begin
        issue = ((occ + {1'b0, infl}) < 2'd2) || pop;
        if (issue && rem == LEN_WIDTH'(1))
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last)
          state_nx = IDLE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      raddr     <= '0;
      rem       <= '0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      occ       <= 2'd0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      bdata[0]  <= '0;
      bdata[1]  <= '0;
      blast[0]  <= 1'b0;
      blast[1]  <= 1'b0;
    end else begin
      state     <= state_nx;
      infl      <= issue;
      infl_last <= issue && (rem == LEN_WIDTH'(1));
      if (accept) begin
        raddr <= cmd_addr;
        rem   <= cmd_len;
      end else if (issue) begin
        raddr <= raddr + ADDR_WIDTH'(1);
        rem   <= rem - LEN_WIDTH'(1);
      end
      if (push) begin
        bdata[wptr] <= bram_rdata;
        blast[wptr] <= infl_last;
        wptr        <= ~wptr;
      end
      if (pop)
        rptr <= ~rptr;
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef PKT_BRAM_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count  <= '0;
      word_count <= '0;
    end else begin
      if (pop)
        word_count <= word_count + 32'd1;
      if (pop && m_last)
        pkt_count <= pkt_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pkt_bram_reader.md
Name: pkt_bram_reader

Overview:
- Read-side engine for a packet buffer built on the team's simple dual-port BRAM (1-cycle registered read, `re`-gated).
- Accepts a command of start address plus length in words. Drives the BRAM read port and emits the words as a valid/ready stream with `m_last` on the final word.
- Absorbs BRAM read latency and downstream backpressure with an internal 2-entry buffer. Sits between the packet store and the egress port logic.

Parameters:
- DATA_WIDTH, 32, BRAM word width and `m_data` width.
- ADDR_WIDTH, 4, BRAM address width; depth is 2**ADDR_WIDTH words.
- LEN_WIDTH, ADDR_WIDTH+1, width of `cmd_len`; allows a full-depth packet.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, command can be accepted
- cmd_addr  in  ADDR_WIDTH  start word address
- cmd_len  in  LEN_WIDTH  packet length in words
- bram_re  out  1  BRAM read enable
- bram_raddr  out  ADDR_WIDTH  BRAM read address
- bram_rdata  in  DATA_WIDTH  BRAM read data, valid the cycle after `bram_re`
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accepts word
- m_data  out  DATA_WIDTH  stream word
- m_last  out  1  final word of packet
- busy  out  1  packet in progress

Behaviour:
- Interface: one clock `clk`. `rst` is synchronous, active-high.
- Reset values: cmd_ready=1, bram_re=0, bram_raddr=0, m_valid=0, m_data=0, m_last=0, busy=0. All counters and buffer occupancy cleared.
- Reset mid-packet aborts the packet:
  - no further `bram_re`;
  - `m_valid` is 0 in the cycle after `rst`;
  - the in-flight read result is discarded.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready with len>0, latch addr/len and go to READ. With len==0, go to DONE.
  - READ: issue reads until len reads are issued, then go to DRAIN.
  - DRAIN: wait until the last word handshakes, then go to IDLE.
  - DONE: one cycle, no output, then go to IDLE. Handles zero length.
- `cmd_ready` is 1 only in IDLE. `busy` = !IDLE.
- Read issue rule:
  - In READ, `bram_re` is 1 when (occ + inflight) < 2, or when a pop (m_valid&&m_ready) occurs this cycle.
  - occ = buffer entries, 0..2. inflight = read issued last cycle, 0..1.
  - The buffer never overflows.
- Address and count:
  - `bram_raddr` starts at `cmd_addr` and increments by 1 per issued read.
  - It wraps modulo 2**ADDR_WIDTH with no error.
  - Exactly `cmd_len` reads are issued per packet.
- Buffer:
  - `bram_rdata` is written into the buffer at the clock edge ending the cycle after `bram_re`.
  - Output is taken from the buffer head.
- Latency: command accepted in cycle T → `bram_re` first high in T+1 → `m_valid` first high in T+3.
- Throughput: with m_ready held 1, one word per cycle is sustained after the first.
- Stream rules:
  - While m_valid&&!m_ready, `m_data`/`m_last` stay stable and `m_valid` stays 1.
  - `m_valid` never drops without a handshake.
- `m_last` is 1 only with the word whose index equals len-1 (tracked per buffer entry).
- cmd_valid with cmd_ready=0 is ignored; no queuing.
- A new command is accepted no earlier than the cycle after the last-word handshake.

Optional Feature:
- Macro: PKT_BRAM_READER_STATS_EN.
- When defined, the module adds:
  - output `pkt_count`, 16 bits, reset 0;
  - output `word_count`, 32 bits, reset 0.
- Counter behaviour:
  - `pkt_count` increments on each m_last handshake.
  - `word_count` increments on each m_valid&&m_ready.
  - Both wrap silently. Zero-length commands count nothing.
- When undefined, neither port nor any counter logic exists, and behaviour is otherwise identical.

Test Plan:
- BRAM preloaded mem[i]=0x100+i. Command addr=2, len=4, m_ready=1 → bram_re high cycles T+1..T+4 at addr 2..5. m_data 0x102..0x105 on cycles T+3..T+6, m_last only with 0x105. busy falls, cmd_ready=1 at T+7.
- Same command, m_ready toggling 1,0,0,1,… → no word lost or duplicated, data held stable while stalled, bram_re never leaves occ+inflight above 2.
- Command addr=14, len=4, ADDR_WIDTH=4 → bram_raddr sequence 14, 15, 0, 1, data 0x10E, 0x10F, 0x100, 0x101.
- Command len=0 → no bram_re, no m_valid, cmd_ready low exactly one cycle, then 1.
- Command len=8. Assert rst for 1 cycle after the 3rd word handshake → m_valid=0, bram_re=0, cmd_ready=1 next cycle. A following len=2 command returns exactly 2 words.
- STATS_EN defined: two packets of len 3 and 5 → pkt_count=2, word_count=8. After rst, both are 0.
